conv_mac_unit: RTL and testbench
================================

// Module: conv_mac_unit
// PURPOSE
//  Multiply-accumulate engine for one convolution output pixel of the MNIST CNN datapath.
//  Accepts a stream of N_TAPS signed (pixel, weight) pairs, sums the products onto a bias,
//  and saturates the sum. Optionally applies ReLU. Presents the result over a valid/ready handshake.
//  Sits directly upstream of the feature-map output Register and drives its ld/clr/dataIn.
// PARAMETERS
//  DATA_W  8   width of signed pixel and weight operands
//  ACC_W   24  signed accumulator width; must be >= 2*DATA_W + clog2(N_TAPS) + 1
//  N_TAPS  9   products per output pixel (3x3 kernel)
//  OUT_W   16  signed result width after saturation
//  RELU    1   1: negative results forced to 0; 0: pass signed result
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous, active-low reset
//  flush     in   1       synchronous abort of the current window
//  in_valid  in   1       pixel/weight/bias valid
//  in_ready  out  1       MAC can accept a beat
//  pixel     in   DATA_W  signed activation
//  weight    in   DATA_W  signed kernel coefficient
//  bias      in   OUT_W   signed bias; sampled only on the first beat of a window
//  out_valid out  1       result held on out_data
//  out_ready in   1       consumer accepts result
//  out_data  out  OUT_W   saturated (and optionally ReLU'd) result
//  out_ld    out  1       = out_valid & out_ready; load strobe for downstream Register
//  busy      out  1       window in progress (tap_cnt != 0 or out_valid)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, acc=0, tap_cnt=0, out_valid=0, out_data=0, in_ready=0
//    while rst is low. Reset mid-window or mid-DONE discards everything immediately.
//  - FSM states: IDLE, ACC, DONE. in_ready=1 in IDLE and ACC, 0 in DONE.
//  - Beat accepted when in_valid & in_ready. Product = signed pixel*weight (2*DATA_W bits),
//    sign-extended to ACC_W.
//  - IDLE: on a beat, acc <= sext(bias) + product, tap_cnt <= 1, go to ACC.
//    If N_TAPS==1, go to DONE instead.
//  - ACC: on a beat, acc <= acc + product, tap_cnt++. When the beat is tap N_TAPS-1:
//    tap_cnt <= 0 and go to DONE. No beat in a cycle: everything holds; bubbles are legal.
//  - DONE: out_valid=1 and out_data is registered on the DONE-entry edge. Result is out_data =
//    sat(acc) clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then max(0,.) if RELU=1.
//    out_data and out_valid stay stable until out_ready. On the handshake cycle, out_ld=1,
//    next state is IDLE, and out_valid=0 from the next cycle. No new beat is accepted in
//    DONE, so result-to-next-window bubble = 1 cycle minimum.
//  - Latency: out_valid rises 1 cycle after the edge that accepts the last beat.
//  - Accumulator wraps modulo 2^ACC_W (parameter rule makes it unreachable). Saturation
//    happens only at the output.
//  - flush=1 (any state): next edge forces IDLE, tap_cnt=0, acc=0, out_valid=0, and no out_ld.
//    flush has priority over a same-cycle beat or handshake.
//  - out_data holds its last value after handshake; downstream must qualify it with out_valid.
// STRUCTURE
//  - Shared CNN package/header: DATA_W, ACC_W, OUT_W, N_TAPS defaults and FSM state encodings
//    (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
//  - One sub-module: sat_relu (combinational, ACC_W -> OUT_W clamp plus optional ReLU),
//    reused by the pooling and FC stages.
//  - Top contains the FSM, tap counter, accumulator and output register.
// TESTING
//  1. bias=0; 9 beats pixel=1, weight=1 back-to-back -> out_valid 1 cycle after 9th beat,
//     out_data=9, out_ld single pulse with out_ready=1.
//  2. RELU=0, bias=0; 9 beats pixel=-128, weight=127 -> sum -146304 -> out_data=-32768.
//     With RELU=1 -> out_data=0.
//  3. Repeat test 1 with out_ready=0 for 5 cycles -> out_data stays 9, in_ready=0, out_ld=0.
//     out_ld=1 exactly on the cycle out_ready rises.
//  4. Test 1 with in_valid low on alternate cycles, bias=100 -> out_data=109; tap_cnt frozen
//     during bubbles.
//  5. flush after 4 beats, then a fresh 9-beat window (pixel=2, weight=3, bias=-4) ->
//     out_data=50; no out_ld for the aborted window.
//  6. Drop rst in DONE with out_data=9 -> out_valid=0 and out_data=0 before the next clk edge.
//     After release, test 1 passes again.

Source files
------------

// File: rtl/conv_mac_unit_pkg.sv
// Shared CNN datapath definitions: default widths and the MAC window FSM encoding.
// Imported by the MAC engine and the reusable saturation/ReLU stage.
package conv_mac_unit_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_N_TAPS = 9;
    localparam int DEF_OUT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_e;

endpackage

// File: rtl/conv_mac_unit_sat_relu.sv
// Combinational narrowing stage: clamps a wide signed accumulator into OUT_W bits,
// then optionally zeroes negative results (ReLU). Shared with the pooling and FC stages.
module sat_relu
    import conv_mac_unit_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] res_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
        if (a > MAX_V)
            return MAX_V[OUT_W-1:0];
        else if (a < MIN_V)
            return MIN_V[OUT_W-1:0];
        else
            return a[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] x);
        if ((RELU != 0) && (x < 0))
            return '0;
        else
            return x;
    endfunction

    assign res_o = relu(clamp(acc_i));

endmodule

// File: rtl/conv_mac_unit.sv
// MAC engine for one convolution output pixel: accumulates N_TAPS signed pixel*weight
// products onto a bias, then presents the saturated (optionally ReLU'd) result on valid/ready.
module conv_mac_unit
    import conv_mac_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] pixel,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [OUT_W-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_ld,
    output logic                     busy
);

    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

    mac_state_e                state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [OUT_W-1:0]    sat_res;
    logic                       beat;

    assign beat     = in_valid & in_ready_q;
    assign prod     = pixel * weight;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias);
    // The first beat of a window seeds the sum with the bias instead of the running total.
    assign acc_sum  = ((state_q == ST_IDLE) ? bias_ext : acc_q) + prod_ext;

    sat_relu #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .RELU  (RELU)
    ) u_sat_relu (
        .acc_i (acc_sum),
        .res_o (sat_res)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d = acc_sum;
                    if (N_TAPS == 1) begin
                        tap_d       = '0;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = sat_res;
                    end else begin
                        tap_d   = TAP_W'(1);
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_d = acc_sum;
                    if (tap_q == LAST_TAP) begin
                        tap_d       = '0;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = sat_res;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tap_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over any same-cycle beat or handshake; out_data keeps its stale value.
        if (flush) begin
            state_d     = ST_IDLE;
            tap_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ld    = out_valid_q & out_ready & ~flush;
    assign busy      = (tap_q != '0) | out_valid_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Bench for conv_mac_unit: two instances (ReLU on / off) share all inputs; results are
// compared against a table of hand-derived values and a plain-arithmetic window model.
module tb_conv_mac_unit;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int N      = 9;
    localparam int OUT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic signed [DATA_W-1:0] pixel;
    logic signed [DATA_W-1:0] weight;
    logic signed [OUT_W-1:0]  bias;

    logic                    in_ready_a, out_valid_a, out_ld_a, busy_a;
    logic signed [OUT_W-1:0] out_data_a;
    logic                    in_ready_b, out_valid_b, out_ld_b, busy_b;
    logic signed [OUT_W-1:0] out_data_b;

    conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_TAPS(N), .OUT_W(OUT_W), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .pixel(pixel), .weight(weight), .bias(bias), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_ld(out_ld_a), .busy(busy_a)
    );

    conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_TAPS(N), .OUT_W(OUT_W), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .pixel(pixel), .weight(weight), .bias(bias), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_ld(out_ld_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int b;
        int p;
        int w;
        int exp_relu;
        int exp_lin;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias plus the sum of the products, clamped to OUT_W, optional ReLU.
    function automatic int model(input int b, input int px[N], input int wt[N], input bit relu);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        s  = b;
        for (int i = 0; i < N; i++)
            s += longint'(px[i]) * longint'(wt[i]);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic run_window(input int b, input int px[N], input int wt[N],
                              input int gap_min, input int gap_max, input int stall,
                              input bit do_hs, output int res_a, output int res_b);
        int to;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin
                in_valid = 1'b0;
                pixel    = DATA_W'($urandom);
                weight   = DATA_W'($urandom);
                bias     = OUT_W'($urandom);
                step();
                check("tap_hold_in_bubble", dut_a.tap_q, i);
            end
            pixel    = DATA_W'(px[i]);
            weight   = DATA_W'(wt[i]);
            bias     = (i == 0) ? OUT_W'(b) : OUT_W'($urandom);
            in_valid = 1'b1;
            to = 0;
            while (!in_ready_a && to < 20) begin
                step();
                to++;
            end
            if (to >= 20) check("in_ready_timeout", 0, 1);
            if (i == N - 1) check("valid_before_last_beat", out_valid_a, 0);
            step();
        end
        in_valid = 1'b0;
        check("valid_after_last_beat", out_valid_a, 1);
        check("valid_b_after_last_beat", out_valid_b, 1);
        check("in_ready_in_done", in_ready_a, 0);
        check("busy_in_done", busy_a, 1);
        res_a = int'(out_data_a);
        res_b = int'(out_data_b);
        if (do_hs) begin
            repeat (stall) begin
                check("no_ld_while_stalled", out_ld_a, 0);
                step();
                check("data_stable_stalled", out_data_a, res_a);
                check("valid_stable_stalled", out_valid_a, 1);
                check("in_ready_low_stalled", in_ready_a, 0);
            end
            out_ready = 1'b1;
            #1;
            check("out_ld_on_ready", out_ld_a, 1);
            check("out_ld_b_on_ready", out_ld_b, 1);
            step();
            out_ready = 1'b0;
            #1;
            check("valid_drops_after_hs", out_valid_a, 0);
            check("out_ld_single_pulse", out_ld_a, 0);
            check("data_held_after_hs", out_data_a, res_a);
            check("in_ready_after_hs", in_ready_a, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int px[N];
        int wt[N];
        int ra, rb;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pixel = '0; weight = '0; bias = '0;

        // Reset state
        #2;
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_in_ready_b", in_ready_b, 0);
        check("rst_busy", busy_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_out_ld", out_ld_a, 0);
        step();
        step();
        rst = 1'b1;
        step();

        // Table-driven windows: constant pixel/weight across all taps
        tbl[0] = '{0, 1, 1, 9, 9};
        tbl[1] = '{0, -128, 127, 0, -32768};
        tbl[2] = '{-4, 2, 3, 50, 50};
        tbl[3] = '{100, 1, 1, 109, 109};
        tbl[4] = '{0, 127, 127, 32767, 32767};
        tbl[5] = '{0, -128, -128, 32767, 32767};
        tbl[6] = '{-32768, 1, -1, 0, -32768};
        tbl[7] = '{32767, 1, 1, 32767, 32767};
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                px[i] = tbl[t].p;
                wt[i] = tbl[t].w;
            end
            run_window(tbl[t].b, px, wt, 0, 0, t % 3, 1'b1, ra, rb);
            check($sformatf("tbl%0d_relu", t), ra, tbl[t].exp_relu);
            check($sformatf("tbl%0d_lin", t), rb, tbl[t].exp_lin);
        end

        // Long stall: result held 5 cycles with out_ready low
        for (int i = 0; i < N; i++) begin px[i] = 1; wt[i] = 1; end
        run_window(0, px, wt, 0, 0, 5, 1'b1, ra, rb);
        check("stall5_result", ra, 9);

        // Alternate-cycle bubbles, bias 100
        run_window(100, px, wt, 1, 1, 1, 1'b1, ra, rb);
        check("bubble_result", ra, 109);

        // Flush after 4 beats (with a same-cycle beat offered), then fresh window
        for (int i = 0; i < 4; i++) begin
            pixel = 8'sd5; weight = 8'sd5; bias = 16'sd7; in_valid = 1'b1;
            step();
        end
        flush = 1'b1;
        #1;
        check("flush_no_ld", out_ld_a, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_busy_clear", busy_a, 0);
        check("flush_tap_clear", dut_a.tap_q, 0);
        check("flush_valid_clear", out_valid_a, 0);
        for (int i = 0; i < N; i++) begin px[i] = 2; wt[i] = 3; end
        run_window(-4, px, wt, 0, 0, 0, 1'b1, ra, rb);
        check("after_flush_result", ra, 50);

        // Flush in DONE beats a same-cycle handshake
        run_window(-4, px, wt, 0, 0, 0, 1'b0, ra, rb);
        check("done_flush_precheck", ra, 50);
        out_ready = 1'b1; flush = 1'b1;
        #1;
        check("done_flush_no_ld", out_ld_a, 0);
        step();
        out_ready = 1'b0; flush = 1'b0;
        #1;
        check("done_flush_valid", out_valid_a, 0);
        check("done_flush_in_ready", in_ready_a, 1);

        // Async reset while holding a result in DONE
        for (int i = 0; i < N; i++) begin px[i] = 1; wt[i] = 1; end
        run_window(0, px, wt, 0, 0, 0, 1'b0, ra, rb);
        check("pre_reset_result", ra, 9);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid_a, 0);
        check("async_rst_data", out_data_a, 0);
        check("async_rst_in_ready", in_ready_a, 0);
        check("async_rst_busy", busy_a, 0);
        #1;
        rst = 1'b1;
        step();
        run_window(0, px, wt, 0, 0, 1, 1'b1, ra, rb);
        check("post_reset_result", ra, 9);

        // Randomized windows with random bubbles and stalls
        for (int r = 0; r < 25; r++) begin
            int b;
            b = int'($urandom_range(65535, 0)) - 32768;
            for (int i = 0; i < N; i++) begin
                px[i] = int'($urandom_range(255, 0)) - 128;
                wt[i] = int'($urandom_range(255, 0)) - 128;
            end
            run_window(b, px, wt, 0, 2, int'($urandom_range(3, 0)), 1'b1, ra, rb);
            check($sformatf("rand%0d_relu", r), ra, model(b, px, wt, 1'b1));
            check($sformatf("rand%0d_lin", r), rb, model(b, px, wt, 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
